// File: rtl/onehot_request_arbiter.sv
// Round-robin arbiter turning raw request edges into a stream of one-hot grants
// with a valid/ready handshake; feeds the 4-to-2 encoder's d input.
module onehot_request_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_onehot,
  output logic         grant_valid,
  input  logic         grant_ready,
  output logic [N-1:0] pending,
  output logic         drop
);

  localparam int PW = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    req_q;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            valid_q, valid_d;
  logic            drop_q, drop_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic [N-1:0]    edge_s;
  logic            accept_s;
  logic [N-1:0]    acc_mask_s;
  logic [N-1:0]    rem_s;
  logic [PW-1:0]   gidx_s;
  logic [PW-1:0]   nxt_ptr_s;

  // First set bit of v found by scanning upward from index p, wrapping at N.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input logic [PW-1:0] p);
    logic [N-1:0]  g;
    logic          found;
    logic [PW-1:0] idx;
    g     = '0;
    found = 1'b0;
    idx   = p;
    for (int k = 0; k < N; k++) begin
      if (!found && v[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end else begin
        found = found;
      end
      idx = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
    end
    return g;
  endfunction

  // Event capture, accept masking and overrun detection.
  always_comb begin
    edge_s     = req_i & ~req_q;
    accept_s   = valid_q & grant_ready;
    acc_mask_s = accept_s ? grant_q : '0;
    rem_s      = pending_q & ~acc_mask_s;
    pending_d  = rem_s | edge_s;
    drop_d     = |(edge_s & rem_s);
    gidx_s     = '0;
    for (int i = 0; i < N; i++) begin
      gidx_s = grant_q[i] ? PW'(i) : gidx_s;
    end
    nxt_ptr_s  = (gidx_s == PW'(N - 1)) ? '0 : gidx_s + 1'b1;
  end

  // Grant FSM: offer one winner, hold it under backpressure, chain on accept.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pending_q != '0) begin
          grant_d = rr_pick(pending_q, ptr_q);
          valid_d = 1'b1;
          state_d = OFFER;
        end else begin
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      OFFER: begin
        if (accept_s) begin
          ptr_d = nxt_ptr_s;
          // Edges landing this cycle are left for the next arbitration round.
          if (rem_s != '0) begin
            grant_d = rr_pick(rem_s, nxt_ptr_s);
            valid_d = 1'b1;
          end else begin
            grant_d = '0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else begin
          grant_d = grant_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      pending_q <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      drop_q    <= 1'b0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_i;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      drop_q    <= drop_d;
      ptr_q     <= ptr_d;
    end
  end

  assign grant_onehot = grant_q;
  assign grant_valid  = valid_q;
  assign pending      = pending_q;
  assign drop         = drop_q;

endmodule

// File: tb/tb_onehot_request_arbiter.sv
// Scoreboard bench: expected accepted grants are queued when requests are driven
// and compared as each grant is accepted; register state is checked directly.
module tb_onehot_request_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_i;
  logic [3:0] grant_onehot;
  logic       grant_valid;
  logic       grant_ready;
  logic [3:0] pending;
  logic       drop;

  int n_checks;
  int n_errors;
  logic [3:0] exp_q[$];

  onehot_request_arbiter #(.N(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .grant_onehot (grant_onehot),
    .grant_valid  (grant_valid),
    .grant_ready  (grant_ready),
    .pending      (pending),
    .drop         (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst = 1'b1;
    req_i = 4'b0000;
    grant_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Accepted grants are popped from the scoreboard; invariants checked every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("inv", {31'd0, grant_valid ? ($countones(grant_onehot) == 1 && (grant_onehot & ~pending) == 4'b0000)
                                      : (grant_onehot == 4'b0000)}, 32'd1);
      if (grant_valid && grant_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", {28'd0, grant_onehot}, 32'd0);
        end else begin
          chk("grant", {28'd0, grant_onehot}, {28'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    req_i = 4'b1111;
    grant_ready = 1'b0;

    // T1: reset with requests high, release with requests low
    tick();
    tick();
    chk("t1_rst_grant", {28'd0, grant_onehot}, 32'd0);
    chk("t1_rst_valid", {31'd0, grant_valid}, 32'd0);
    chk("t1_rst_pend", {28'd0, pending}, 32'd0);
    chk("t1_rst_drop", {31'd0, drop}, 32'd0);
    req_i = 4'b0000;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_idle_valid", {31'd0, grant_valid}, 32'd0);
      chk("t1_idle_pend", {28'd0, pending}, 32'd0);
    end

    // T2: single event on bit 2
    req_i = 4'b0100;
    grant_ready = 1'b1;
    exp_q.push_back(4'b0100);
    tick();
    req_i = 4'b0000;
    chk("t2_pend", {28'd0, pending}, 32'h4);
    chk("t2_valid_early", {31'd0, grant_valid}, 32'd0);
    tick();
    chk("t2_grant", {28'd0, grant_onehot}, 32'h4);
    chk("t2_valid", {31'd0, grant_valid}, 32'd1);
    tick();
    chk("t2_pend_after", {28'd0, pending}, 32'd0);
    chk("t2_valid_after", {31'd0, grant_valid}, 32'd0);

    // T3: burst from pointer 0, then confirm pointer returned to 0
    do_reset();
    grant_ready = 1'b1;
    req_i = 4'b1111;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    tick();
    req_i = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_burst", {28'd0, grant_onehot}, 32'(4'b0001 << i));
    end
    tick();
    chk("t3_valid_end", {31'd0, grant_valid}, 32'd0);
    chk("t3_pend_end", {28'd0, pending}, 32'd0);
    req_i = 4'b1001;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1000);
    tick();
    req_i = 4'b0000;
    tick();
    chk("t3_ptr0", {28'd0, grant_onehot}, 32'h1);
    tick();
    tick();
    chk("t3_idle", {31'd0, grant_valid}, 32'd0);

    // T4: backpressure and rotation
    do_reset();
    req_i = 4'b0011;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    tick();
    req_i = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold0", {28'd0, grant_onehot}, 32'h1);
    end
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    req_i = 4'b1000;
    chk("t4_next", {28'd0, grant_onehot}, 32'h2);
    tick();
    req_i = 4'b0001;
    tick();
    req_i = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_hold1", {28'd0, grant_onehot}, 32'h2);
    end
    chk("t4_pend", {28'd0, pending}, 32'hB);
    grant_ready = 1'b1;
    tick();
    chk("t4_rot3", {28'd0, grant_onehot}, 32'h8);
    tick();
    chk("t4_rot0", {28'd0, grant_onehot}, 32'h1);
    tick();
    chk("t4_idle", {31'd0, grant_valid}, 32'd0);

    // T5: overrun on a pending bit
    do_reset();
    req_i = 4'b1000;
    exp_q.push_back(4'b1000);
    tick();
    req_i = 4'b0000;
    chk("t5_drop_first", {31'd0, drop}, 32'd0);
    tick();
    chk("t5_grant", {28'd0, grant_onehot}, 32'h8);
    req_i = 4'b1000;
    tick();
    req_i = 4'b0000;
    chk("t5_drop_second", {31'd0, drop}, 32'd1);
    tick();
    chk("t5_drop_pulse", {31'd0, drop}, 32'd0);
    grant_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_idle", {31'd0, grant_valid}, 32'd0);
    chk("t5_pend", {28'd0, pending}, 32'd0);

    // T6: event in the accepting cycle survives; reset mid-offer
    do_reset();
    req_i = 4'b0010;
    exp_q.push_back(4'b0010);
    tick();
    req_i = 4'b0000;
    tick();
    chk("t6_grant", {28'd0, grant_onehot}, 32'h2);
    req_i = 4'b0010;
    grant_ready = 1'b1;
    tick();
    req_i = 4'b0000;
    grant_ready = 1'b0;
    chk("t6_pend_kept", {28'd0, pending}, 32'h2);
    tick();
    chk("t6_regrant", {28'd0, grant_onehot}, 32'h2);
    chk("t6_revalid", {31'd0, grant_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_grant", {28'd0, grant_onehot}, 32'd0);
    chk("t6_rst_valid", {31'd0, grant_valid}, 32'd0);
    chk("t6_rst_pend", {28'd0, pending}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("t6_post_valid", {31'd0, grant_valid}, 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
